tx_arbiter: RTL and testbench

Sequences the shared serial TX channel between the instruction prefetcher and the instruction scheduler. Picks one requester at a time, drives the TX command/data handshake for it, and keeps an ordered record of which requester owns each outstanding reply, so RX data is steered to the right consumer. It sits between the prefetch unit / scheduler and the TX/RX engines, replacing direct scheduler-to-TX wiring.

---
 rtl/tx_arbiter_pkg.sv | 16 +
 rtl/tx_arbiter_reply_fifo.sv | 45 ++++
 rtl/tx_arbiter.sv | 135 +++++++++++++
 tb/tb_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for tx_arbiter: FSM states, reply-owner codes, TX command width.
// The optional starvation guard in tx_arbiter is enabled by defining TX_ARB_STARVE_GUARD_EN.
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 8
`endif

package tx_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  localparam logic OWNER_PF = 1'b0;
  localparam logic OWNER_SC = 1'b1;
endpackage

// File: rtl/tx_arbiter_reply_fifo.sv
// 1-bit-wide ordered record of reply owners; push and pop may coincide, even when full.
module tx_arbiter_reply_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic             w_pop, w_push;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == FULL_CNT);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign head   = empty ? 1'b0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= (r_wr == LAST) ? '0 : r_wr + AW'(1);
      end
      if (w_pop)
        r_rd <= (r_rd == LAST) ? '0 : r_rd + AW'(1);
      r_cnt <= r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end
  end
endmodule

// File: rtl/tx_arbiter.sv
// Shares the TX channel between prefetch and scheduler and steers RX replies by owner.
// Define TX_ARB_STARVE_GUARD_EN to force a prefetch grant after STARVE_LIMIT scheduler wins.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NSHIFT       = 2,
  parameter int REPLY_DEPTH  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pf_req,
  input  logic [`TX_CMD_BITS-1:0] pf_cmd,
  input  logic [NSHIFT-1:0]       pf_data,
  output logic                    pf_grant,
  output logic                    pf_data_next,
  input  logic                    sc_req,
  input  logic [`TX_CMD_BITS-1:0] sc_cmd,
  input  logic [NSHIFT-1:0]       sc_data,
  input  logic                    sc_reserve,
  input  logic                    sc_reply_wanted,
  output logic                    sc_grant,
  output logic                    sc_data_next,
  output logic                    tx_command_valid,
  output logic [`TX_CMD_BITS-1:0] tx_command,
  output logic [NSHIFT-1:0]       tx_data,
  output logic                    tx_reply_wanted,
  input  logic                    tx_command_started,
  input  logic                    tx_data_next,
  input  logic                    tx_done,
  input  logic                    rx_done,
  output logic                    reply_owner,
  output logic                    reply_pending,
  output logic                    rx_orphan
);
  if (REPLY_DEPTH < 1 || (REPLY_DEPTH & (REPLY_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tx_arbiter: REPLY_DEPTH must be a power of two");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("tx_arbiter: STARVE_LIMIT must be at least 1");
  end

  state_t                  r_state;
  logic                    r_owner, r_reply, r_cmd_valid, r_orphan;
  logic [`TX_CMD_BITS-1:0] r_cmd;
  logic w_full, w_empty, w_head, w_started, w_push, w_payload;
  logic w_pf_ok, w_pf_win, w_sc_win, w_pf_force;

  // Both requesters need a free reply slot when they expect a reply; prefetch always does.
  assign w_pf_ok  = pf_req && !sc_reserve && !w_full;
  assign w_pf_win = (r_state == ST_IDLE) && w_pf_ok && (!sc_req || w_pf_force);
  assign w_sc_win = (r_state == ST_IDLE) && sc_req && !(sc_reply_wanted && w_full) && !w_pf_win;

`ifdef TX_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] r_starve;

  assign w_pf_force = (r_starve == LIMIT) && !sc_reserve;

  always_ff @(posedge clk) begin
    if (reset)
      r_starve <= '0;
    else if (r_state == ST_IDLE) begin
      if (w_pf_win || !pf_req)
        r_starve <= '0;
      else if (w_sc_win && r_starve != LIMIT)
        r_starve <= r_starve + SW'(1);
    end
  end
`else
  assign w_pf_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWNER_PF;
      r_reply     <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pf_win || w_sc_win) begin
          r_owner     <= w_pf_win ? OWNER_PF : OWNER_SC;
          r_cmd       <= w_pf_win ? pf_cmd : sc_cmd;
          r_reply     <= w_pf_win ? 1'b1 : sc_reply_wanted;
          r_cmd_valid <= 1'b1;
          r_state     <= ST_CMD;
        end
        ST_CMD: if (tx_command_started) begin
          r_cmd_valid <= 1'b0;
          r_cmd       <= '0;
          r_reply     <= 1'b0;
          r_state     <= ST_PAYLOAD;
        end
        ST_PAYLOAD: if (tx_done) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_orphan <= 1'b0;
    else if (rx_done && w_empty) r_orphan <= 1'b1;
  end

  // Grant is suppressed in a reset cycle so a dropped command is never acknowledged.
  assign w_started = (r_state == ST_CMD) && tx_command_started && !reset;
  assign w_push    = w_started && r_reply;
  assign w_payload = (r_state == ST_PAYLOAD);

  assign pf_grant         = w_started && (r_owner == OWNER_PF);
  assign sc_grant         = w_started && (r_owner == OWNER_SC);
  assign tx_command_valid = r_cmd_valid;
  assign tx_command       = r_cmd;
  assign tx_reply_wanted  = r_reply;
  assign tx_data          = !w_payload ? '0 : (r_owner == OWNER_SC) ? sc_data : pf_data;
  assign pf_data_next     = w_payload && (r_owner == OWNER_PF) && tx_data_next;
  assign sc_data_next     = w_payload && (r_owner == OWNER_SC) && tx_data_next;
  assign reply_owner      = w_head;
  assign reply_pending    = !w_empty;
  assign rx_orphan        = r_orphan;

  tx_arbiter_reply_fifo #(.DEPTH(REPLY_DEPTH)) u_reply_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (r_owner),
    .pop   (rx_done),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );
endmodule

// File: tb/tb_tx_arbiter.sv
// Directed and randomized bench for tx_arbiter against a transaction-level reference model.
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 8
`endif

module tb_tx_arbiter;
  localparam int NSHIFT = 2;
  localparam int DEPTH  = 2;
  localparam int LIMIT  = 4;
  localparam int CW     = `TX_CMD_BITS;

  logic clk = 1'b0;
  logic reset;
  logic pf_req, sc_req, sc_reserve, sc_reply_wanted;
  logic [CW-1:0] pf_cmd, sc_cmd;
  logic [NSHIFT-1:0] pf_data, sc_data;
  logic tx_command_started, tx_data_next, tx_done, rx_done;
  logic pf_grant, sc_grant, pf_data_next, sc_data_next;
  logic tx_command_valid, tx_reply_wanted;
  logic [CW-1:0] tx_command;
  logic [NSHIFT-1:0] tx_data;
  logic reply_owner, reply_pending, rx_orphan;

  always #5 clk = ~clk;

  tx_arbiter #(.NSHIFT(NSHIFT), .REPLY_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pf_req(pf_req), .pf_cmd(pf_cmd), .pf_data(pf_data), .pf_grant(pf_grant),
    .pf_data_next(pf_data_next),
    .sc_req(sc_req), .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_reserve(sc_reserve),
    .sc_reply_wanted(sc_reply_wanted), .sc_grant(sc_grant), .sc_data_next(sc_data_next),
    .tx_command_valid(tx_command_valid), .tx_command(tx_command), .tx_data(tx_data),
    .tx_reply_wanted(tx_reply_wanted), .tx_command_started(tx_command_started),
    .tx_data_next(tx_data_next), .tx_done(tx_done), .rx_done(rx_done),
    .reply_owner(reply_owner), .reply_pending(reply_pending), .rx_orphan(rx_orphan)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_pfg = 0;
  int n_scg = 0;
  bit gseq[$];
  bit auto_eng = 0;
  int eng_pct = 100;

  // Reference model: transaction phase (0 idle, 1 command offered, 2 payload),
  // the current transaction, and the reply owners in arrival order.
  int      m_phase;
  bit      m_owner;
  bit      m_rw;
  logic [CW-1:0] m_cmd;
  bit      m_q[$];
  bit      m_orph;
  int      m_starve;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_rw = 0; m_cmd = '0;
    m_q.delete(); m_orph = 0; m_starve = 0;
  endtask

  task automatic model_update();
    int  used;
    bit  full, pf_elig, sc_elig, force_pf;
    used = m_q.size();
    full = (used >= DEPTH);
    if (reset) begin model_reset(); return; end
    if (rx_done) begin
      if (used > 0) void'(m_q.pop_front());
      else m_orph = 1;
    end
    case (m_phase)
      0: begin
        pf_elig  = pf_req && !sc_reserve && !full;
        sc_elig  = sc_req && !(sc_reply_wanted && full);
        force_pf = 0;
`ifdef TX_ARB_STARVE_GUARD_EN
        force_pf = (m_starve >= LIMIT) && !sc_reserve;
`endif
        if (pf_elig && (!sc_req || force_pf)) begin
          m_phase = 1; m_owner = 0; m_cmd = pf_cmd; m_rw = 1; m_starve = 0;
        end else begin
          if (sc_elig) begin
            m_phase = 1; m_owner = 1; m_cmd = sc_cmd; m_rw = sc_reply_wanted;
            if (pf_req && m_starve < LIMIT) m_starve++;
          end
          if (!pf_req) m_starve = 0;
        end
      end
      1: if (tx_command_started) begin
        if (m_rw) m_q.push_back(m_owner);
        m_phase = 2;
      end
      default: if (tx_done) m_phase = 0;
    endcase
  endtask

  // One cycle: settle inputs, compare every output with the model, advance.
  task automatic step();
    if (auto_eng) begin
      tx_command_started = (m_phase == 1) && ($urandom_range(0, 99) < eng_pct);
      tx_done            = (m_phase == 2) && ($urandom_range(0, 99) < eng_pct);
    end
    #1;
    chk("cmd_valid", tx_command_valid, m_phase == 1);
    chk("command", tx_command, (m_phase == 1) ? m_cmd : '0);
    chk("reply_wanted", tx_reply_wanted, (m_phase == 1) && m_rw);
    chk("pf_grant", pf_grant, !reset && m_phase == 1 && tx_command_started && !m_owner);
    chk("sc_grant", sc_grant, !reset && m_phase == 1 && tx_command_started && m_owner);
    chk("tx_data", tx_data, (m_phase == 2) ? (m_owner ? sc_data : pf_data) : '0);
    chk("pf_data_next", pf_data_next, m_phase == 2 && !m_owner && tx_data_next);
    chk("sc_data_next", sc_data_next, m_phase == 2 && m_owner && tx_data_next);
    chk("reply_pending", reply_pending, m_q.size() > 0);
    chk("reply_owner", reply_owner, (m_q.size() > 0) ? m_q[0] : 1'b0);
    chk("rx_orphan", rx_orphan, m_orph);
    if (pf_grant) begin n_pfg++; gseq.push_back(1'b0); end
    if (sc_grant) begin n_scg++; gseq.push_back(1'b1); end
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    pf_req = 0; sc_req = 0; sc_reserve = 0; sc_reply_wanted = 0;
    pf_cmd = '0; sc_cmd = '0; pf_data = '0; sc_data = '0;
    tx_command_started = 0; tx_data_next = 0; tx_done = 0; rx_done = 0;
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  initial begin
    bit exp_seq[10];
    int base;
    quiet();
    reset = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset state
    do_reset();
    #1;
    chk("rst_valid", tx_command_valid, 0);
    chk("rst_pending", reply_pending, 0);
    chk("rst_orphan", rx_orphan, 0);

    // Prefetch alone with its reply
    pf_req = 1; pf_cmd = 8'h5A; pf_data = 2'b10;
    #1 chk("pf_valid_n", tx_command_valid, 0);
    step();
    pf_req = 0; tx_command_started = 1;
    #1 chk("pf_valid_n1", tx_command_valid, 1);
    chk("pf_cmd", tx_command, 8'h5A);
    chk("pf_grant_pulse", pf_grant, 1);
    step();
    tx_command_started = 0; tx_data_next = 1;
    #1 chk("pf_tx_data", tx_data, 2'b10);
    chk("pf_dnext", pf_data_next, 1);
    chk("pf_pending", reply_pending, 1);
    chk("pf_owner", reply_owner, 0);
    tx_done = 1; step();
    tx_done = 0; tx_data_next = 0; rx_done = 1; step();
    rx_done = 0;
    #1 chk("pf_drained", reply_pending, 0);
    step();

    // Simultaneous requests: scheduler first, prefetch right after
    pf_req = 1; sc_req = 1; sc_reply_wanted = 1; sc_cmd = 8'hA5; sc_data = 2'b01;
    step();
    tx_command_started = 1;
    #1 chk("both_sc_first", sc_grant, 1);
    chk("both_pf_not", pf_grant, 0);
    step();
    sc_req = 0; tx_command_started = 0; tx_done = 1; step();
    tx_done = 0; step();
    #1 chk("both_pf_k2", tx_command_valid, 1);
    tx_command_started = 1; pf_req = 0;
    #1 chk("both_pf_grant", pf_grant, 1);
    step();
    tx_command_started = 0; tx_done = 1; step();
    tx_done = 0;
    #1 chk("order_first_sc", reply_owner, 1);
    rx_done = 1; step();
    #1 chk("order_then_pf", reply_owner, 0);
    step();
    rx_done = 0; step();

    // Reservation blocks prefetch
    sc_reserve = 1; pf_req = 1;
    base = n_pfg;
    for (int i = 0; i < 20; i++) step();
    chk("reserve_no_grant", n_pfg - base, 0);
    quiet(); step();

    // Full reply FIFO holds prefetch in idle
    auto_eng = 1; eng_pct = 100; pf_req = 1; base = n_pfg;
    for (int i = 0; i < 30 && n_pfg < base + 2; i++) step();
    chk("full_two_grants", n_pfg - base, 2);
    for (int i = 0; i < 8; i++) step();
    chk("full_held", n_pfg - base, 2);
    rx_done = 1; step(); rx_done = 0;
    for (int i = 0; i < 10 && n_pfg < base + 3; i++) step();
    chk("full_released", n_pfg - base, 3);
    rx_done = 1; step();
    for (int i = 0; i < 10 && n_pfg < base + 4; i++) begin
      rx_done = (m_phase == 1);
      step();
    end
    pf_req = 0; rx_done = 0;
    chk("pushpop_grant", n_pfg - base, 4);
    for (int i = 0; i < 4; i++) step();
    #1 chk("pushpop_kept", reply_pending, 1);
    rx_done = 1; step(); step(); rx_done = 0; step();

    // Grant sequence with both requesting continuously
    do_reset();
    gseq.delete();
    pf_req = 1; sc_req = 1; sc_reply_wanted = 0; rx_done = 1;
    for (int i = 0; i < 200 && gseq.size() < 10; i++) step();
    for (int i = 0; i < 10; i++) exp_seq[i] = 1'b1;
`ifdef TX_ARB_STARVE_GUARD_EN
    exp_seq[4] = 1'b0; exp_seq[9] = 1'b0;
`endif
    chk("seq_len", gseq.size(), 10);
    for (int i = 0; i < 10 && i < gseq.size(); i++)
      chk($sformatf("seq_%0d", i), gseq[i], exp_seq[i]);
    quiet(); step(); step();

    // Orphan reply flag is sticky until reset
    do_reset();
    #1 chk("orph_clear", rx_orphan, 0);
    rx_done = 1; step(); rx_done = 0;
    #1 chk("orph_set", rx_orphan, 1);
    pf_req = 1; step(); pf_req = 0;
    for (int i = 0; i < 6; i++) step();
    rx_done = 1; step(); rx_done = 0;
    #1 chk("orph_sticky", rx_orphan, 1);
    do_reset();
    #1 chk("orph_reset", rx_orphan, 0);

    // Randomized traffic
    eng_pct = 40;
    for (int i = 0; i < 3000; i++) begin
      pf_req          = ($urandom_range(0, 1) == 1);
      sc_req          = ($urandom_range(0, 2) == 0);
      sc_reserve      = ($urandom_range(0, 6) == 0);
      sc_reply_wanted = ($urandom_range(0, 1) == 1);
      pf_cmd          = CW'($urandom);
      sc_cmd          = CW'($urandom);
      pf_data         = NSHIFT'($urandom);
      sc_data         = NSHIFT'($urandom);
      tx_data_next    = ($urandom_range(0, 1) == 1);
      rx_done         = ($urandom_range(0, 3) == 0);
      reset           = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0; quiet(); auto_eng = 0;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
